// File: rtl/seq_fsm_pkg.sv
// rtl/seq_fsm_pkg.sv - shared types, sizing helpers and pattern failure function for mealy_seq_fsm
package seq_fsm_pkg;

  localparam int PAT_MAX_W = 1024;
  localparam logic [7:0] DEFAULT_PATTERN = 8'h78;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_ADVANCE,
    STEP_MATCH,
    STEP_FALLBACK,
    STEP_RESTART
  } step_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sw_of(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Longest proper border of pattern symbols 0..len-1 (where an overlapping match resumes).
  function automatic int prefix_fallback(input logic [PAT_MAX_W-1:0] pat, input int sym_w, input int len);
    int res;
    logic ok;
    res = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        for (int b = 0; b < sym_w; b++)
          if (pat[(len - k + j) * sym_w + b] != pat[j * sym_w + b]) ok = 1'b0;
      if (ok) res = k;
    end
    return res;
  endfunction

endpackage

// File: rtl/mealy_seq_fsm_if.sv
// rtl/mealy_seq_fsm_if.sv - symbol stream and detector status bundle
interface mealy_seq_fsm_if #(
  parameter int SYM_W = 2,
  parameter int CNT_W = 4,
  parameter int SW    = 2
);
  logic             en;
  logic [SYM_W-1:0] sym;
  logic             match;
  logic [CNT_W-1:0] out;
  logic [SW-1:0]    currentstate;
  logic [SW-1:0]    nextstate;

  modport master (output en, sym, input match, out, currentstate, nextstate);
  modport slave  (input en, sym, output match, out, currentstate, nextstate);
endinterface

// File: rtl/seq_match_cmp.sv
// rtl/seq_match_cmp.sv - does (pattern prefix of length state) + sym end with pattern prefix K
module seq_match_cmp #(
  parameter int                     SYM_W   = 2,
  parameter int                     DEPTH   = 4,
  parameter logic [DEPTH*SYM_W-1:0] PATTERN = '0,
  parameter int                     K       = 0,
  parameter int                     SW      = 2
) (
  input  logic [SW-1:0]    state,
  input  logic [SYM_W-1:0] sym,
  output logic             hit
);

  function automatic logic [SYM_W-1:0] pat_sym(input int i);
    return PATTERN[i*SYM_W +: SYM_W];
  endfunction

  // The history is implied by the state, so only sym and pattern-vs-pattern symbols are compared.
  always_comb begin
    hit = 1'b1;
    if (K != 0) begin
      if (int'(state) < K || int'(state) >= DEPTH) begin
        hit = 1'b0;
      end else begin
        if (sym != pat_sym(K - 1)) hit = 1'b0;
        for (int j = 0; j < K - 1; j++)
          if (pat_sym(int'(state) - K + 1 + j) != pat_sym(j)) hit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mealy_seq_fsm.sv
// rtl/mealy_seq_fsm.sv - parametrised Mealy pattern detector with wrapping match counter
module mealy_seq_fsm
  import seq_fsm_pkg::*;
#(
  parameter int                     SYM_W   = 2,
  parameter int                     DEPTH   = 4,
  parameter logic [DEPTH*SYM_W-1:0] PATTERN = (DEPTH*SYM_W)'(DEFAULT_PATTERN),
  parameter int                     OVERLAP = 1,
  parameter int                     CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  mealy_seq_fsm_if.slave bus
);

  localparam int SW = sw_of(DEPTH);
  localparam logic [SW-1:0] FULL_FB = SW'(prefix_fallback(PAT_MAX_W'(PATTERN), SYM_W, DEPTH));

  logic [SW-1:0]    cs;
  logic [SW-1:0]    ns;
  logic [SW-1:0]    fb;
  logic [DEPTH-1:0] hit;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic             m;
  step_e            step;

  function automatic logic [SYM_W-1:0] pat_sym(input int i);
    return PATTERN[i*SYM_W +: SYM_W];
  endfunction

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    seq_match_cmp #(
      .SYM_W  (SYM_W),
      .DEPTH  (DEPTH),
      .PATTERN(PATTERN),
      .K      (k),
      .SW     (SW)
    ) u_cmp (
      .state(cs),
      .sym  (bus.sym),
      .hit  (hit[k])
    );
  end

  always_comb begin
    fb    = '0;
    found = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!found && hit[k]) begin
        fb    = SW'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    step = STEP_HOLD;
    if (bus.en) begin
      if (int'(cs) >= DEPTH)
        step = STEP_RESTART;
      else if (bus.sym == pat_sym(int'(cs)))
        step = (cs == SW'(DEPTH - 1)) ? STEP_MATCH : STEP_ADVANCE;
      else
        step = STEP_FALLBACK;
    end
  end

  always_comb begin
    case (step)
      STEP_HOLD:     ns = cs;
      STEP_ADVANCE:  ns = cs + 1'b1;
      STEP_MATCH:    ns = (OVERLAP != 0) ? FULL_FB : '0;
      STEP_FALLBACK: ns = fb;
      default:       ns = '0;
    endcase
    if (!rst) ns = '0;
    m = rst && (step == STEP_MATCH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cs  <= '0;
      cnt <= '0;
    end else begin
      cs <= ns;
      if (m) cnt <= cnt + 1'b1;
    end
  end

  assign bus.match        = m;
  assign bus.out          = cnt;
  assign bus.currentstate = cs;
  assign bus.nextstate    = ns;

endmodule

// File: tb/tb_mealy_seq_fsm.sv
// tb/tb_mealy_seq_fsm.sv - table-driven scoreboard bench for mealy_seq_fsm
module tb_mealy_seq_fsm;

  typedef struct {
    logic       en;
    logic [1:0] sym;
    logic       m;
    logic [1:0] cs;
    logic [1:0] ns;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] sym = 2'b00;
  int         sel = 0;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt;
  logic [3:0] sb[$];
  vec_t cur[$];
  vec_t t_def[$], t_ov1[$], t_ov0[$], t_fb[$], t_pre[$], t_cnt[$];

  logic       act_match;
  logic [3:0] act_out;
  logic [1:0] act_cs, act_ns;

  always #5 clk = ~clk;

  mealy_seq_fsm_if #(.SYM_W(2), .CNT_W(4), .SW(2)) if0 ();
  mealy_seq_fsm_if #(.SYM_W(1), .CNT_W(4), .SW(2)) if1 ();
  mealy_seq_fsm_if #(.SYM_W(1), .CNT_W(4), .SW(2)) if2 ();
  mealy_seq_fsm_if #(.SYM_W(2), .CNT_W(2), .SW(2)) if3 ();

  assign if0.en = en;  assign if0.sym = sym;
  assign if1.en = en;  assign if1.sym = sym[0];
  assign if2.en = en;  assign if2.sym = sym[0];
  assign if3.en = en;  assign if3.sym = sym;

  mealy_seq_fsm d0 (.clk(clk), .rst(rst), .bus(if0));
  mealy_seq_fsm #(.SYM_W(1), .DEPTH(4), .PATTERN(4'b0101), .OVERLAP(1)) d1 (.clk(clk), .rst(rst), .bus(if1));
  mealy_seq_fsm #(.SYM_W(1), .DEPTH(4), .PATTERN(4'b0101), .OVERLAP(0)) d2 (.clk(clk), .rst(rst), .bus(if2));
  mealy_seq_fsm #(.CNT_W(2)) d3 (.clk(clk), .rst(rst), .bus(if3));

  always_comb begin
    case (sel)
      1:       begin act_match = if1.match; act_out = if1.out;         act_cs = if1.currentstate; act_ns = if1.nextstate; end
      2:       begin act_match = if2.match; act_out = if2.out;         act_cs = if2.currentstate; act_ns = if2.nextstate; end
      3:       begin act_match = if3.match; act_out = {2'b00, if3.out}; act_cs = if3.currentstate; act_ns = if3.nextstate; end
      default: begin act_match = if0.match; act_out = if0.out;         act_cs = if0.currentstate; act_ns = if0.nextstate; end
    endcase
  end

  function automatic vec_t mk(input logic e, input logic [1:0] s, input logic m, input logic [1:0] c, input logic [1:0] n);
    vec_t v;
    v.en = e; v.sym = s; v.m = m; v.cs = c; v.ns = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0d expected %0d", name, sel, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("rst_cs", act_cs, 0);
    chk("rst_out", act_out, 0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exp_cnt = '0;
  endtask

  task automatic run_vecs(input logic [3:0] mask);
    logic [3:0] e;
    foreach (cur[i]) begin
      @(negedge clk);
      en = cur[i].en; sym = cur[i].sym;
      #1;
      chk("match", act_match, cur[i].m);
      chk("currentstate", act_cs, cur[i].cs);
      chk("nextstate", act_ns, cur[i].ns);
      if (cur[i].m) exp_cnt = (exp_cnt + 4'd1) & mask;
      sb.push_back(exp_cnt);
      @(posedge clk); #1;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out", act_out, e);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    t_def = '{mk(1,0,0,0,1), mk(1,2,0,1,2), mk(1,3,0,2,3), mk(1,1,1,3,0), mk(0,0,0,0,0)};
    t_ov1 = '{mk(1,1,0,0,1), mk(1,0,0,1,2), mk(1,1,0,2,3), mk(1,0,1,3,2), mk(1,1,0,2,3), mk(1,0,1,3,2)};
    t_ov0 = '{mk(1,1,0,0,1), mk(1,0,0,1,2), mk(1,1,0,2,3), mk(1,0,1,3,0), mk(1,1,0,0,1), mk(1,0,0,1,2)};
    t_fb  = '{mk(1,0,0,0,1), mk(1,2,0,1,2), mk(1,0,0,2,1), mk(1,2,0,1,2), mk(1,3,0,2,3), mk(1,1,1,3,0)};
    t_pre = '{mk(1,0,0,0,1), mk(1,2,0,1,2), mk(1,3,0,2,3)};
    begin
      logic [1:0] pat [4];
      logic [1:0] after;
      pat = '{2'd0, 2'd2, 2'd3, 2'd1};
      for (int p = 0; p < 5; p++)
        for (int s = 0; s < 4; s++) begin
          after = (s == 3) ? 2'd0 : 2'(s + 1);
          t_cnt.push_back(mk(1, pat[s], s == 3, 2'(s), after));
          t_cnt.push_back(mk(0, pat[after], 0, after, after));
        end
    end

    sel = 0; rst = 1'b0; en = 1'b1; sym = 2'b00;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_rst_cs", act_cs, 0);
      chk("hold_rst_out", act_out, 0);
      chk("hold_rst_match", act_match, 0);
      chk("hold_rst_ns", act_ns, 0);
    end
    @(negedge clk); rst = 1'b1; en = 1'b0;
    exp_cnt = '0;

    sel = 0; do_reset(); cur = t_def; run_vecs(4'hf);
    sel = 1; do_reset(); cur = t_ov1; run_vecs(4'hf);
    chk("ov1_total", act_out, 2);
    sel = 2; do_reset(); cur = t_ov0; run_vecs(4'hf);
    chk("ov0_total", act_out, 1);
    sel = 0; do_reset(); cur = t_fb;  run_vecs(4'hf);

    sel = 0; do_reset(); cur = t_pre; run_vecs(4'hf);
    @(negedge clk); rst = 1'b0; en = 1'b1; sym = 2'd1; #1;
    chk("midrst_match", act_match, 0);
    chk("midrst_ns", act_ns, 0);
    chk("midrst_cs", act_cs, 3);
    @(posedge clk); #1;
    chk("midrst_cs_after", act_cs, 0);
    chk("midrst_out", act_out, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("post_match", act_match, 0);
    chk("post_ns", act_ns, 0);
    @(posedge clk); #1;
    chk("post_cs", act_cs, 0);
    chk("post_out", act_out, 0);
    en = 1'b0;

    sel = 3; do_reset(); cur = t_cnt; run_vecs(4'h3);
    chk("cnt_wrap_final", act_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mealy_seq_fsm.md
# mealy_seq_fsm

Parametrised Mealy sequence detector, the successor of the fixed two-input `mealyfsm`. It consumes one SYM_W-bit symbol per enabled cycle and raises a combinational `match` in the cycle the final symbol of a programmable DEPTH-symbol pattern arrives. It keeps a wrapping match counter on `out`, and can run in overlapping or non-overlapping mode. It sits directly behind the input-synchronising logic that drives `{a,b}`, and exposes `currentstate` and `nextstate` for bench probing.

## Interface
- SYM_W, 2: symbol width; default matches the legacy `{a,b}` pair.
- DEPTH, 4: pattern length in symbols; legal range 2..16.
- PATTERN, 8'h78: packed DEPTH*SYM_W bits; symbol k is PATTERN[k*SYM_W +: SYM_W], and symbol 0 is received first. The default is 00, 10, 11, 01.
- OVERLAP, 1: 1 allows matches to share symbols; 0 restarts after each match.
- CNT_W, 4: width of the match counter `out`.
- SW, derived = max(1, $clog2(DEPTH)): state width, a localparam.
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  symbol-valid qualifier.
- sym  input  SYM_W  current symbol.
- match  output  1  Mealy detect pulse, combinational.
- out  output  CNT_W  number of matches since reset, modulo 2^CNT_W.
- currentstate  output  SW  number of pattern symbols currently matched (0..DEPTH-1).
- nextstate  output  SW  combinational next value of `currentstate`.

## Operation
- State s means the last s accepted symbols equal pattern symbols 0..s-1, and s is the longest such prefix.
- en=0: `nextstate` = `currentstate`, `match` = 0, and `out` holds.
- en=1, s<DEPTH-1, sym==P[s]: next state is s+1.
- en=1, s==DEPTH-1, sym==P[DEPTH-1]: `match` = 1 and `out` increments by 1 (wrapping).
  - The next state is the fallback over the complete pattern when OVERLAP=1.
  - The next state is 0 when OVERLAP=0.
- en=1, sym!=P[s]: next state is the fallback: the largest k<=s such that (P[0..s-1] followed by sym) ends with P[0..k-1]. It may be 0.
- The fallback is computed combinationally by a descending-k compare loop, with no ROM. Pattern-only failure values may be computed at elaboration by a constant function.
- Reset (rst=0 at a rising edge): `currentstate` = 0 and `out` = 0.
- `match` is forced 0 while rst=0, and `nextstate` reads 0 while rst=0.
- Reset has priority over en in any cycle, including mid-pattern.
- Unused state encodings (DEPTH not a power of 2) go to 0 on the next enabled cycle.

## Timing
- `match` is valid in the same cycle as the completing symbol, with zero latency.
- `out` reflects a match one clock later.
- `currentstate` follows `nextstate` one clock later; there is no pipeline.
- A match and counter wrap in the same cycle give out = 0 on the next edge, with no flag.
- rst deasserts at an edge; the first symbol is accepted on the following edge if en=1.

## Structure
- Package `seq_fsm_pkg` holds:
  - the `clog2` helper and the SW computation rule;
  - the default PATTERN constant;
  - the `prefix_fallback` constant function (pattern-only failure table).
- Sub-module `seq_match_cmp`: for a given k, checks whether the history plus sym ends with pattern prefix k; instantiated DEPTH times via generate.
- Top level contains the state register, the counter, the fallback priority select, and the output assigns.

## Test plan
- Default parameters, rst=0 held for 3 clocks, then released: currentstate = 0, out = 0, match = 0 throughout reset.
- Default parameters, en=1, sym = 00, 10, 11, 01: match pulses on the 4th symbol only; out = 1 one clock later; currentstate runs 0, 1, 2, 3, 0.
- SYM_W=1, DEPTH=4, pattern 1,0,1,0 (PATTERN = 4'b0101), stream 1,0,1,0,1,0:
  - OVERLAP=1: match on symbols 4 and 6; out = 2.
  - OVERLAP=0: match on symbol 4 only; out = 1.
- Default parameters, stream 00, 10, 00, 10, 11, 01: the mismatch at symbol 3 falls back to state 1 (sym 00 == P[0]); match on symbol 6; out = 1.
- Default parameters, 00, 10, 11, then rst=0 for one clock, then 01: no match; currentstate = 0 after reset; out stays 0.
- CNT_W=2, 5 back-to-back default patterns with en toggling 1,0,1,0 between symbols: out reads 1, 2, 3, 0, 1; en=0 cycles never change state.
